// File: rtl/spiram_arbiter_if.sv
// spiram_arbiter_if
//   Bundles every bus-side signal of the two-port SPI RAM arbiter: the two
//   requester ports (packed, port N in slice N) and the single downstream
//   SPI RAM controller handshake, plus the sticky timeout flag.
//
//   Modports:
//     slave  - the arbiter's view: consumes requester strobes, produces port
//              busy/read data, drives the controller strobes, consumes
//              controller busy/read data.
//     master - the surrounding system's view (requesters + controller).
//
//   Signals:
//     req_rd[1:0], req_wr[1:0]  per-port 1-cycle read/write strobes
//     req_word_address[39:0]    port N address in [20N+19:20N]
//     req_wdata[63:0]           port N write data in [32N+31:32N]
//     req_rdata[63:0]           port N read data in [32N+31:32N]
//     req_rbusy/req_wbusy[1:0]  per-port read/write in flight
//     mem_rd, mem_wr            strobes to controller
//     mem_word_address[19:0]    address of granted request
//     mem_wdata[31:0]           write data of granted request
//     mem_rdata[31:0]           controller read data
//     mem_rbusy, mem_wbusy      controller busy flags
//     timeout_err               sticky abort indicator
interface spiram_arbiter_if;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [39:0] req_word_address;
  logic [63:0] req_wdata;
  logic [63:0] req_rdata;
  logic [1:0]  req_rbusy;
  logic [1:0]  req_wbusy;
  logic        mem_rd;
  logic        mem_wr;
  logic [19:0] mem_word_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        timeout_err;

  modport slave (
    input  req_rd, req_wr, req_word_address, req_wdata,
    output req_rdata, req_rbusy, req_wbusy,
    output mem_rd, mem_wr, mem_word_address, mem_wdata,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    output timeout_err
  );

  modport master (
    output req_rd, req_wr, req_word_address, req_wdata,
    input  req_rdata, req_rbusy, req_wbusy,
    input  mem_rd, mem_wr, mem_word_address, mem_wdata,
    output mem_rdata, mem_rbusy, mem_wbusy,
    input  timeout_err
  );
endinterface

// File: rtl/spiram_arbiter.sv
// spiram_arbiter
//   Shares one SPI RAM controller between two requesters (port 0 = CPU data
//   port, port 1 = secondary master). Each port may hold one captured request;
//   the FSM grants one at a time, drives the controller's rd/wr strobe until
//   the controller reports busy (or a timeout expires), waits for busy to
//   clear, then spends one DONE cycle retiring the request so the controller
//   can return to its accept state before the next strobe.
//
//   Ports:
//     clk    system clock
//     reset  synchronous active-high reset (abandons any transaction)
//     bus    spiram_arbiter_if.slave (requester ports + controller handshake)
//
//   Parameters:
//     ISSUE_TIMEOUT  cycles (1..255) a strobe is held waiting for busy
//     ABORT_RDATA    read data returned for a timed-out read
//
//   Build option:
//     SPIRAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins when both
//                               ports are pending; otherwise round-robin.
module spiram_arbiter #(
  parameter int          ISSUE_TIMEOUT = 16,
  parameter logic [31:0] ABORT_RDATA   = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  spiram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        abort_reg, abort_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        mem_rd_reg, mem_rd_next;
  logic        mem_wr_reg, mem_wr_next;
  logic [19:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        timeout_err_reg, timeout_err_next;

  // Per-port views of the captured request slots.
  logic [1:0]  pending;
  logic [1:0]  port_is_rd;
  logic [1:0]  port_rbusy;
  logic [1:0]  port_wbusy;
  logic [1:0]  release_port;
  logic [19:0] port_addr  [2];
  logic [31:0] port_wdata [2];
  logic [31:0] port_rdata [2];

  logic        mem_busy;
  logic [31:0] done_rdata;
  logic        pick;

  assign mem_busy   = bus.mem_rbusy | bus.mem_wbusy;
  // Read data delivered to the granted port when it retires.
  assign done_rdata = abort_reg ? ABORT_RDATA : bus.mem_rdata;

  // ---------------------------------------------------------------------
  // Request capture slots, one per port. A slot accepts a strobe only while
  // empty; it is emptied solely by the DONE cycle of its own grant, so a
  // strobe arriving during DONE is still ignored.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_port
      logic        pend_reg;
      logic        is_rd_reg;
      logic        rbusy_reg;
      logic        wbusy_reg;
      logic [19:0] addr_reg;
      logic [31:0] wdata_reg;
      logic [31:0] rdata_reg;
      logic        strobe;

      assign strobe = bus.req_rd[gi] | bus.req_wr[gi];
      assign release_port[gi] = (state_reg == ST_DONE) && (grant_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          pend_reg  <= 1'b0;
          is_rd_reg <= 1'b0;
          rbusy_reg <= 1'b0;
          wbusy_reg <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          rdata_reg <= '0;
        end else if (release_port[gi]) begin
          pend_reg  <= 1'b0;
          rbusy_reg <= 1'b0;
          wbusy_reg <= 1'b0;
          if (is_rd_reg) begin
            rdata_reg <= done_rdata;
          end
        end else if (!pend_reg && strobe) begin
          // Read wins when both strobes are high in the same cycle.
          pend_reg  <= 1'b1;
          is_rd_reg <= bus.req_rd[gi];
          rbusy_reg <= bus.req_rd[gi];
          wbusy_reg <= ~bus.req_rd[gi];
          addr_reg  <= bus.req_word_address[20*gi +: 20];
          wdata_reg <= bus.req_wdata[32*gi +: 32];
        end
      end

      assign pending[gi]    = pend_reg;
      assign port_is_rd[gi] = is_rd_reg;
      assign port_rbusy[gi] = rbusy_reg;
      assign port_wbusy[gi] = wbusy_reg;
      assign port_addr[gi]  = addr_reg;
      assign port_wdata[gi] = wdata_reg;
      assign port_rdata[gi] = rdata_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Grant selection. With a single pending port, ~pending[0] selects it
  // (01 -> port 0, 10 -> port 1); only the both-pending case differs.
  // ---------------------------------------------------------------------
`ifdef SPIRAM_ARB_FIXED_PRIO_EN
  assign pick = ~pending[0];
`else
  logic last_grant_reg;

  // Starts at 1 so that port 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == ST_DONE) begin
      last_grant_reg <= grant_reg;
    end
  end

  assign pick = (&pending) ? ~last_grant_reg : ~pending[0];
`endif

  // ---------------------------------------------------------------------
  // Arbitration FSM: state register.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= 1'b0;
      abort_reg       <= 1'b0;
      cnt_reg         <= '0;
      mem_rd_reg      <= 1'b0;
      mem_wr_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      abort_reg       <= abort_next;
      cnt_reg         <= cnt_next;
      mem_rd_reg      <= mem_rd_next;
      mem_wr_reg      <= mem_wr_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration FSM: next-state and registered-output logic.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    abort_next       = abort_reg;
    cnt_next         = cnt_reg;
    mem_rd_next      = mem_rd_reg;
    mem_wr_next      = mem_wr_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    timeout_err_next = timeout_err_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (|pending) begin
          grant_next     = pick;
          mem_addr_next  = port_addr[pick];
          mem_wdata_next = port_wdata[pick];
          mem_rd_next    = port_is_rd[pick];
          mem_wr_next    = ~port_is_rd[pick];
          cnt_next       = '0;
          abort_next     = 1'b0;
          state_next     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_busy) begin
          // Controller accepted: the strobe has done its job.
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          state_next  = ST_WAIT;
        end else if (cnt_reg == 8'(ISSUE_TIMEOUT - 1)) begin
          mem_rd_next = 1'b0;
          mem_wr_next = 1'b0;
          abort_next  = 1'b1;
          state_next  = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_WAIT: begin
        if (!mem_busy) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // Port retirement happens in the capture slots; this cycle also
        // guarantees one strobe-free cycle before the next grant.
        if (abort_reg) begin
          timeout_err_next = 1'b1;
        end
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs (all driven straight from registers).
  // ---------------------------------------------------------------------
  assign bus.mem_rd           = mem_rd_reg;
  assign bus.mem_wr           = mem_wr_reg;
  assign bus.mem_word_address = mem_addr_reg;
  assign bus.mem_wdata        = mem_wdata_reg;
  assign bus.timeout_err      = timeout_err_reg;
  assign bus.req_rbusy        = port_rbusy;
  assign bus.req_wbusy        = port_wbusy;
  assign bus.req_rdata        = {port_rdata[1], port_rdata[0]};

endmodule
